drain_collector: RTL
====================

# drain_collector

Bottom-edge drain controller and output collector for the output-stationary systolic array. After compute, it sequences `drain_enable` to shift the stationary 64-bit accumulators out of the bottom PE row one row per cycle. It requantizes each captured row to 16-bit lanes (arithmetic shift, round, saturate per precision mode), buffers the rows in a small FIFO, and presents them on a valid/ready stream to the writeback path. It is the receiving end of the vertical accumulator bus.

## Interface
- `ROWS`, 4: array rows, i.e. accumulator rows drained per job.
- `COLS`, 4: array columns, i.e. lanes per row.
- `ACC_WIDTH`, 64: accumulator width per lane.
- `DATA_WIDTH`, 16: output lane width.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of 2 and ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to drain. Ignored while `busy`.
- `shift_amt` in 6: requant right-shift, 0..63. Sampled at accepted `start`.
- `precision_mode` in `precision_mode_t`: output saturation range. Sampled at accepted `start`.
- `bottom_data` in COLS*ACC_WIDTH: bottom-row `data_to_bottom`; lane c is bits [c*64 +: 64].
- `drain_enable` out 1: to all PEs.
- `acc_clear` out 1: to all PEs.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accept.
- `out_data` out COLS*DATA_WIDTH: requantized row; lane c is bits [c*16 +: 16].
- `out_row` out $clog2(ROWS): array row index of `out_data`.
- `busy` out 1: a job is in progress.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, DRAIN, CLEAR, FLUSH.
  - IDLE: on `start`, latch `shift_amt` and `precision_mode`, clear the row counter k, go to DRAIN.
  - DRAIN: `drain_enable` = (fifo_count < FIFO_DEPTH). Each cycle `drain_enable`=1:
    - capture `bottom_data`, requantize, push to FIFO with `out_row` = ROWS-1-k;
    - k++;
    - after capture k = ROWS-1, go to CLEAR.
  - CLEAR: `acc_clear`=1 for exactly one cycle, `drain_enable`=0, then go to FLUSH.
  - FLUSH: wait for the FIFO to empty. In the cycle the FIFO is observed empty: `done`=1, go to IDLE.
- `busy`=1 in DRAIN, CLEAR and FLUSH.
- Stall rule: when the FIFO is full, `drain_enable` is held at 0. PE accumulators then hold, and no capture occurs. No row is ever lost or duplicated.
- `drain_enable` is a function of registered state and registered fifo_count only. A same-cycle pop does not free a slot.
- Requant, per lane, with s = `shift_amt`:
  - r = (acc + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in a 65-bit signed intermediate (no overflow on the rounding add).
  - Saturate r: INT4 to [-8,7]; INT8 to [-128,127]; INT16 to [-32768,32767].
  - Sign-extend the result to 16 bits.
  - MODE_RSVD produces 0.
- FIFO: push on capture, pop on `out_valid && out_ready`. Simultaneous push and pop is legal when the FIFO is non-empty. Pointers wrap modulo FIFO_DEPTH.
- `start` asserted while `busy` is ignored, with no side effects.
- Reset mid-job: FSM goes to IDLE, FIFO is emptied, all outputs return to reset values. Partially drained PE state is the upstream controller's concern.

## Timing
- Reset values: `drain_enable`=0, `acc_clear`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `busy`=0, `done`=0.
- `start` at cycle 0 gives DRAIN, `busy`=1 and `drain_enable`=1 at cycle 1.
- The PE muxes `data_to_bottom` combinationally on `drain_enable`. The first capture edge (end of cycle 1) therefore sees row ROWS-1; successive edges see rows ROWS-2, …, 0.
- Capture-to-`out_valid` latency is 1 cycle: the registered requant output is written to the FIFO.
- With `out_ready`=1 throughout and ROWS=4:
  - captures occur at the end of cycles 1–4, `out_valid` rows in cycles 2–5;
  - `acc_clear` is asserted in cycle 5;
  - `done` is asserted in cycle 6, with IDLE in cycle 7.
- `out_data` and `out_row` are stable while `out_valid && !out_ready`.

## Structure
- Shared package / `defines.sv`: `precision_mode_t` (existing), `ACC_WIDTH`, `DATA_WIDTH`, and a new `drain_state_t` enum {IDLE, DRAIN, CLEAR, FLUSH}.
- Sub-module `requant_lane`: combinational round/shift/saturate of one 64-bit lane to 16 bits, instantiated COLS times.
- The FIFO is inline: a register array plus pointers and a count.

## Test plan
- Basic drain, ROWS=COLS=4, s=0, INT16: row r lane c accumulators = 100*r+c, `out_ready`=1. Expect rows in order 3, 2, 1, 0 with lanes 300–303 … 0–3. `acc_clear` is high for exactly one cycle, then `done` pulses.
- Round/saturate:
  - acc = 0x17, s=4, INT8 → 1 (0x17 = 23; 23+8 = 31, 31>>>4 = 1);
  - acc = -24, s=4 → -1 (-24+8 = -16, -16>>>4 = -1);
  - acc = 5000, s=0, INT8 → 127;
  - acc = -5000, s=0, INT4 → 0xFFF8;
  - MODE_RSVD → 0.
- Backpressure: FIFO_DEPTH=2, `out_ready`=0 for 10 cycles. Expect `drain_enable` to go 0 after 2 captures. Releasing ready delivers all 4 rows with no loss or duplicate.
- Boundary: `out_ready` toggling every cycle. Simultaneous push and pop with count held; pointer wrap over 3 jobs gives correct order.
- `start` pulsed while `busy` → ignored; the job completes once with a single `done`.
- `rst_n` asserted during DRAIN after 2 captures → all outputs reach reset values immediately. A subsequent `start` runs a clean job.

Source files
------------

// File: rtl/drain_collector_pkg.sv
// -----------------------------------------------------------------------------
// drain_collector_pkg
// Shared types and widths for the bottom-edge drain/collect path of the
// output-stationary systolic array.
//   precision_mode_t : output saturation range selected per job
//   drain_state_t    : drain controller FSM state
//   ACC_WIDTH        : accumulator width per lane (64)
//   DATA_WIDTH       : requantized output lane width (16)
// -----------------------------------------------------------------------------
package drain_collector_pkg;

    localparam int ACC_WIDTH  = 64;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_INT4  = 2'd0,
        MODE_INT8  = 2'd1,
        MODE_INT16 = 2'd2,
        MODE_RSVD  = 2'd3
    } precision_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        FLUSH = 2'd3
    } drain_state_t;

endpackage

// File: rtl/requant_lane.sv
// -----------------------------------------------------------------------------
// requant_lane
// Combinational round / arithmetic-shift / saturate of one 64-bit signed
// accumulator to a sign-extended 16-bit lane.
//   acc            in  : signed accumulator
//   shift_amt      in  : right shift 0..63 (round-half-up before shifting)
//   precision_mode in  : saturation range (INT4/INT8/INT16), RSVD gives 0
//   lane           out : requantized value
// -----------------------------------------------------------------------------
module requant_lane
    import drain_collector_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [5:0]            shift_amt,
    input  precision_mode_t       precision_mode,
    output logic [DATA_WIDTH-1:0] lane
);

    // One extra bit so the rounding add can never overflow.
    localparam int WIDE = ACC_WIDTH + 1;

    logic signed [WIDE-1:0] wide;
    logic signed [WIDE-1:0] rounding;
    logic signed [WIDE-1:0] sum;
    logic signed [WIDE-1:0] shifted;
    logic signed [WIDE-1:0] lo;
    logic signed [WIDE-1:0] hi;

    always_comb begin
        wide     = $signed({acc[ACC_WIDTH-1], acc});
        rounding = '0;
        if (shift_amt != 6'd0) begin
            rounding = WIDE'(1) << (shift_amt - 6'd1);
        end
        sum     = wide + rounding;
        shifted = sum >>> shift_amt;

        case (precision_mode)
            MODE_INT4: begin
                lo = WIDE'(-8);
                hi = WIDE'(7);
            end
            MODE_INT8: begin
                lo = WIDE'(-128);
                hi = WIDE'(127);
            end
            MODE_INT16: begin
                lo = WIDE'(-32768);
                hi = WIDE'(32767);
            end
            default: begin
                lo = '0;
                hi = '0;
            end
        endcase

        // Bounds are sign-extended values, so their low bits are already the
        // 16-bit sign-extended saturated result.
        if (precision_mode == MODE_RSVD) begin
            lane = '0;
        end else if (shifted > hi) begin
            lane = hi[DATA_WIDTH-1:0];
        end else if (shifted < lo) begin
            lane = lo[DATA_WIDTH-1:0];
        end else begin
            lane = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/drain_collector.sv
// -----------------------------------------------------------------------------
// drain_collector
// Sequences drain_enable to shift accumulator rows out of the bottom PE row,
// requantizes each captured row, buffers rows in a small FIFO and streams
// them out on a valid/ready interface.
//   start/shift_amt/precision_mode in : job request, parameters sampled at start
//   bottom_data    in  : bottom PE row data, lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//   drain_enable   out : shift accumulators down one row this cycle
//   acc_clear      out : clear PE accumulators (one cycle after draining)
//   out_valid/out_ready/out_data/out_row : output row stream
//   busy/done      out : job in progress / one-cycle completion pulse
//   state          out : FSM state, for observation
//
// Handshake: a row transfers on a rising clk edge where out_valid && out_ready;
// out_data/out_row hold steady while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module drain_collector
    import drain_collector_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ACC_WIDTH  = drain_collector_pkg::ACC_WIDTH,
    parameter int DATA_WIDTH = drain_collector_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [5:0]                 shift_amt,
    input  precision_mode_t            precision_mode,
    input  logic [COLS*ACC_WIDTH-1:0]  bottom_data,
    output logic                       drain_enable,
    output logic                       acc_clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*DATA_WIDTH-1:0] out_data,
    output logic [$clog2(ROWS)-1:0]    out_row,
    output logic                       busy,
    output logic                       done,
    output drain_state_t               state
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0]           k;
    logic [5:0]                 shift_q;
    precision_mode_t            mode_q;
    logic [COLS*DATA_WIDTH-1:0] row_requant;

    logic [COLS*DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ROW_W-1:0]           mem_row  [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       push;
    logic                       pop;

    // Only registered state and count feed drain_enable: a pop in the same
    // cycle does not open a slot, which keeps the PE shift free of any
    // combinational path from out_ready.
    assign drain_enable = (state == DRAIN) && (count < CNT_W'(FIFO_DEPTH));
    assign push         = drain_enable;
    assign out_valid    = (count != '0);
    assign pop          = out_valid && out_ready;
    assign acc_clear    = (state == CLEAR);
    assign busy         = (state != IDLE);
    assign done         = (state == FLUSH) && (count == '0);

    // The stale head entry is masked so outputs read zero whenever empty.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_row  = out_valid ? mem_row[rd_ptr]  : '0;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        requant_lane u_lane (
            .acc            (bottom_data[c*ACC_WIDTH +: ACC_WIDTH]),
            .shift_amt      (shift_q),
            .precision_mode (mode_q),
            .lane           (row_requant[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            shift_q <= '0;
            mode_q  <= MODE_INT16;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= shift_amt;
                        mode_q  <= precision_mode;
                        k       <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_enable) begin
                        if (k == LAST_ROW) begin
                            state <= CLEAR;
                        end else begin
                            k <= k + ROW_W'(1);
                        end
                    end
                end
                CLEAR:   state <= FLUSH;
                FLUSH:   if (count == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Row k of the drain sequence is array row ROWS-1-k (bottom row first).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= row_requant;
            mem_row[wr_ptr]  <= LAST_ROW - k;
        end
    end

endmodule
